// File: rtl/instruction_fetcher.sv
// Instruction fetch front end: holds the PC, issues one memory read at a time and presents one instruction to the Decoder.
// Optional direct-mapped I-cache when IFETCH_ICACHE_EN is defined (default build has no cache storage).

module instruction_fetcher #(
    parameter logic [31:0] RESET_PC       = 32'h0,
    parameter int          ICACHE_IDX_BIT = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear,
    input  logic [31:0] rob_clear_pc,
    output logic        inst_valid,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_data,
    input  logic [31:0] f_next_pc,
    input  logic        f_ok,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    // state   | meaning
    // S_REQ   | request for pc offered to memory (or served by the cache)
    // S_WAIT  | request accepted, waiting for its response
    // S_HOLD  | instruction presented, waiting for f_ok
    // S_DRAIN | flushed while a response is outstanding; drop it on arrival
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

    state_t      state;
    logic [31:0] pc;
    logic        cache_hit;
    logic [31:0] cache_rdata;
    logic        req_accept;
    logic        resp_take;

    assign mem_req_valid = (state == S_REQ) && rst_in && !cache_hit;
    assign mem_req_addr  = {pc[31:2], 2'b00};
    assign req_accept    = rdy_in && mem_req_ready && mem_req_valid;
    assign resp_take     = rdy_in && mem_resp_valid;

`ifdef IFETCH_ICACHE_EN
    localparam int LINES = 1 << ICACHE_IDX_BIT;
    localparam int TAG_W = 30 - ICACHE_IDX_BIT;

    logic [LINES-1:0]              line_valid;
    logic [TAG_W-1:0]              line_tag  [LINES];
    logic [31:0]                   line_data [LINES];
    logic [ICACHE_IDX_BIT-1:0]     idx;
    logic [TAG_W-1:0]              tag;
    logic                          fill;

    assign idx         = pc[ICACHE_IDX_BIT+1:2];
    assign tag         = pc[31:ICACHE_IDX_BIT+2];
    assign cache_hit   = (state == S_REQ) && line_valid[idx] && (line_tag[idx] == tag);
    assign cache_rdata = line_data[idx];
    // Only responses that are actually presented fill a line; drained ones never do.
    assign fill        = rst_in && !rob_clear && (state == S_WAIT) && resp_take;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            line_valid <= '0;
        end else if (fill) begin
            line_valid[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (fill) begin
            line_tag[idx]  <= tag;
            line_data[idx] <= mem_resp_data;
        end
    end
`else
    assign cache_hit   = 1'b0;
    assign cache_rdata = 32'h0;
`endif

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            inst_valid <= 1'b0;
            inst_addr  <= RESET_PC;
            inst_data  <= 32'h0;
        end else if (rob_clear) begin
            pc         <= rob_clear_pc;
            inst_valid <= 1'b0;
            case (state)
                S_REQ:   state <= req_accept ? S_DRAIN : S_REQ;
                S_WAIT:  state <= resp_take  ? S_REQ   : S_DRAIN;
                // A response landing on a repeated flush still retires the outstanding read.
                S_DRAIN: state <= resp_take  ? S_REQ   : S_DRAIN;
                default: state <= S_REQ;
            endcase
        end else if (rdy_in) begin
            case (state)
                S_REQ: begin
                    if (cache_hit) begin
                        inst_data  <= cache_rdata;
                        inst_addr  <= pc;
                        inst_valid <= 1'b1;
                        state      <= S_HOLD;
                    end else if (mem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        inst_data  <= mem_resp_data;
                        inst_addr  <= pc;
                        inst_valid <= 1'b1;
                        state      <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (f_ok) begin
                        pc         <= f_next_pc;
                        inst_valid <= 1'b0;
                        state      <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (mem_resp_valid) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetcher.sv
// Self-checking bench for instruction_fetcher: directed scenarios, then randomized traffic against a PC-sequence model.
// Memory is a responder process returning a fixed function of the word address after a programmable latency.

module tb_instruction_fetcher;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        rob_clear = 1'b0;
    logic [31:0] rob_clear_pc = 32'h0;
    logic        inst_valid;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic [31:0] f_next_pc = 32'h0;
    logic        f_ok = 1'b0;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready = 1'b0;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = 32'h0;

    int checks = 0;
    int errors = 0;

    int ready_pct = 0;
    int lat = 2;
    bit rand_lat = 1'b0;

    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'h0;

    always #5 clk_in = ~clk_in;

    instruction_fetcher #(.RESET_PC(32'h0), .ICACHE_IDX_BIT(6)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .rob_clear(rob_clear), .rob_clear_pc(rob_clear_pc),
        .inst_valid(inst_valid), .inst_addr(inst_addr), .inst_data(inst_data),
        .f_next_pc(f_next_pc), .f_ok(f_ok),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[17:2], ~a[17:2]} ^ 32'h9e37_79b9;
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = 32'($urandom_range(0, 127)) << 2;
        if ($urandom_range(7) == 0) p[1:0] = 2'($urandom_range(3));
        return p;
    endfunction

    // Memory responder: decides after the test drivers, one cycle per falling edge.
    initial begin
        bit pend_before;
        forever begin
            @(negedge clk_in);
            #1;
            mem_resp_valid = 1'b0;
            mem_resp_data  = 32'h0;
            if (!rst_in) begin
                pend = 1'b0;
            end else if (pend && rdy_in) begin
                if (pend_cnt <= 1) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = mem_word(pend_addr);
                    pend = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            pend_before   = pend;
            mem_req_ready = ($urandom_range(99) < ready_pct);
            if (mem_req_valid === 1'b1 && mem_req_ready && rdy_in && rst_in) begin
                checks++;
                if (pend_before) begin
                    errors++;
                    $display("FAIL outstanding: second request 0x%08h issued while one pending, want none", mem_req_addr);
                end
                pend      = 1'b1;
                pend_cnt  = rand_lat ? $urandom_range(1, 4) : lat;
                pend_addr = mem_req_addr;
            end
        end
    end

    task automatic wait_valid(input int budget, input string name);
        int n = 0;
        while (inst_valid !== 1'b1 && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        checks++;
        if (inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s: inst_valid timeout, got %b want 1", name, inst_valid);
        end
    endtask

    task automatic test_reset();
        ready_pct = 0;
        rst_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        checks++;
        if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst_addr !== 32'h0 || inst_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: req_valid=%b inst_valid=%b addr=%h data=%h, want 0 0 0 0",
                     mem_req_valid, inst_valid, inst_addr, inst_data);
        end
        rst_in = 1'b1;
        @(negedge clk_in);
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_first_req: valid=%b addr=%h, want 1 00000000", mem_req_valid, mem_req_addr);
        end
    endtask

    task automatic test_fetch_hold();
        ready_pct = 100;
        lat = 2;
        @(negedge clk_in);
        @(negedge clk_in);
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL resp_latency_early: inst_valid=%b, want 0", inst_valid);
        end
        @(negedge clk_in);
        checks++;
        if (inst_valid !== 1'b1 || inst_addr !== 32'h0 || inst_data !== mem_word(32'h0)) begin
            errors++;
            $display("FAIL first_inst: valid=%b addr=%h data=%h, want 1 00000000 %h",
                     inst_valid, inst_addr, inst_data, mem_word(32'h0));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            checks++;
            if (inst_valid !== 1'b1 || inst_addr !== 32'h0 || inst_data !== mem_word(32'h0) || mem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable: valid=%b addr=%h data=%h req=%b, want 1 00000000 %h 0",
                         inst_valid, inst_addr, inst_data, mem_req_valid, mem_word(32'h0));
            end
        end
        f_ok = 1'b1;
        f_next_pc = 32'h4;
        @(negedge clk_in);
        f_ok = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h4) begin
            errors++;
            $display("FAIL accept_next: valid=%b req=%b addr=%h, want 0 1 00000004", inst_valid, mem_req_valid, mem_req_addr);
        end
    endtask

    task automatic test_next_pc();
        wait_valid(10, "next_pc_wait4");
        checks++;
        if (inst_addr !== 32'h4 || inst_data !== mem_word(32'h4)) begin
            errors++;
            $display("FAIL inst_at_4: addr=%h data=%h, want 00000004 %h", inst_addr, inst_data, mem_word(32'h4));
        end
        f_ok = 1'b1;
        f_next_pc = 32'h1000;
        @(negedge clk_in);
        f_ok = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h1000) begin
            errors++;
            $display("FAIL jump_req: req=%b addr=%h, want 1 00001000", mem_req_valid, mem_req_addr);
        end
        wait_valid(10, "next_pc_wait1000");
        checks++;
        if (inst_addr !== 32'h1000 || inst_data !== mem_word(32'h1000)) begin
            errors++;
            $display("FAIL inst_at_1000: addr=%h data=%h, want 00001000 %h", inst_addr, inst_data, mem_word(32'h1000));
        end
    endtask

    task automatic test_flush_inflight();
        bit stale = 1'b0;
        int n = 0;
        lat = 4;
        f_ok = 1'b1;
        f_next_pc = 32'h8;
        @(negedge clk_in);
        f_ok = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8) begin
            errors++;
            $display("FAIL flush_req8: req=%b addr=%h, want 1 00000008", mem_req_valid, mem_req_addr);
        end
        @(negedge clk_in);
        rob_clear = 1'b1;
        rob_clear_pc = 32'h200;
        @(negedge clk_in);
        rob_clear = 1'b0;
        lat = 2;
        checks++;
        if (inst_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drain: valid=%b req=%b, want 0 0", inst_valid, mem_req_valid);
        end
        while (mem_req_valid !== 1'b1 && n < 12) begin
            @(negedge clk_in);
            if (inst_valid !== 1'b0) stale = 1'b1;
            n++;
        end
        checks++;
        if (stale || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h200) begin
            errors++;
            $display("FAIL flush_redirect: stale_presented=%b req=%b addr=%h, want 0 1 00000200", stale, mem_req_valid, mem_req_addr);
        end
        wait_valid(10, "flush_wait200");
        checks++;
        if (inst_addr !== 32'h200 || inst_data !== mem_word(32'h200)) begin
            errors++;
            $display("FAIL inst_at_200: addr=%h data=%h, want 00000200 %h", inst_addr, inst_data, mem_word(32'h200));
        end
    endtask

    task automatic test_clear_vs_ok();
        f_ok = 1'b1;
        f_next_pc = 32'h10;
        rob_clear = 1'b1;
        rob_clear_pc = 32'h300;
        @(negedge clk_in);
        f_ok = 1'b0;
        rob_clear = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h300) begin
            errors++;
            $display("FAIL clear_wins: valid=%b req=%b addr=%h, want 0 1 00000300", inst_valid, mem_req_valid, mem_req_addr);
        end
        wait_valid(10, "clear_wait300");
        checks++;
        if (inst_addr !== 32'h300 || inst_data !== mem_word(32'h300)) begin
            errors++;
            $display("FAIL inst_at_300: addr=%h data=%h, want 00000300 %h", inst_addr, inst_data, mem_word(32'h300));
        end
    endtask

    task automatic test_freeze();
        rdy_in = 1'b0;
        f_ok = 1'b1;
        f_next_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            checks++;
            if (inst_valid !== 1'b1 || inst_addr !== 32'h300 || inst_data !== mem_word(32'h300)) begin
                errors++;
                $display("FAIL freeze_hold: valid=%b addr=%h data=%h, want 1 00000300 %h",
                         inst_valid, inst_addr, inst_data, mem_word(32'h300));
            end
        end
        rdy_in = 1'b1;
        @(negedge clk_in);
        f_ok = 1'b0;
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL unfreeze_accept: valid=%b, want 0", inst_valid);
        end
`ifdef IFETCH_ICACHE_EN
        checks++;
        if (mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL cache_no_req: req=%b, want 0", mem_req_valid);
        end
        @(negedge clk_in);
        checks++;
        if (inst_valid !== 1'b1 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL cache_hit_latency: valid=%b req=%b, want 1 0", inst_valid, mem_req_valid);
        end
`else
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL refetch_req: req=%b addr=%h, want 1 00000000", mem_req_valid, mem_req_addr);
        end
        wait_valid(10, "refetch_wait0");
`endif
        checks++;
        if (inst_addr !== 32'h0 || inst_data !== mem_word(32'h0)) begin
            errors++;
            $display("FAIL refetch_inst: addr=%h data=%h, want 00000000 %h", inst_addr, inst_data, mem_word(32'h0));
        end
    endtask

    // Model: the presented instruction is always mem[exp_pc]; exp_pc moves on flush or accepted f_ok.
    task automatic test_random();
        logic [31:0] exp_pc = 32'h0;
        bit prev_valid = 1'b1;
        bit prev_accept = 1'b0;
        bit prev_clear = 1'b0;
        int accepted = 0;
        ready_pct = 60;
        rand_lat = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk_in);
            checks++;
            if ((prev_accept || prev_clear) && inst_valid !== 1'b0) begin
                errors++;
                $display("FAIL rand_drop cyc=%0d: valid=%b, want 0", cyc, inst_valid);
            end else if (!(prev_accept || prev_clear) && prev_valid && inst_valid !== 1'b1) begin
                errors++;
                $display("FAIL rand_keep cyc=%0d: valid=%b, want 1", cyc, inst_valid);
            end
            if (inst_valid === 1'b1) begin
                checks++;
                if (inst_addr !== exp_pc || inst_data !== mem_word(exp_pc)) begin
                    errors++;
                    $display("FAIL rand_inst cyc=%0d: addr=%h data=%h, want %h %h", cyc, inst_addr, inst_data, exp_pc, mem_word(exp_pc));
                end
            end
            if (mem_req_valid === 1'b1) begin
                checks++;
                if (mem_req_addr !== {exp_pc[31:2], 2'b00}) begin
                    errors++;
                    $display("FAIL rand_req cyc=%0d: addr=%h, want %h", cyc, mem_req_addr, {exp_pc[31:2], 2'b00});
                end
            end
            rdy_in = ($urandom_range(9) != 0);
            #2;
            rob_clear    = ($urandom_range(19) == 0);
            rob_clear_pc = rand_pc();
            f_ok         = $urandom_range(1) == 1;
            f_next_pc    = rand_pc();
            prev_valid   = (inst_valid === 1'b1);
            prev_clear   = rob_clear;
            prev_accept  = !rob_clear && rdy_in && f_ok && prev_valid;
            if (rob_clear) exp_pc = rob_clear_pc;
            else if (prev_accept) exp_pc = f_next_pc;
            if (prev_accept) accepted++;
        end
        @(negedge clk_in);
        rob_clear = 1'b0;
        f_ok = 1'b0;
        rdy_in = 1'b1;
        checks++;
        if (accepted < 100) begin
            errors++;
            $display("FAIL rand_progress: accepted=%0d, want >= 100", accepted);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch_hold();
        test_next_pc();
        test_flush_inflight();
        test_clear_vs_ok();
        test_freeze();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
